// File: rtl/pwm_load_sequencer.sv
// rtl/pwm_load_sequencer.sv - frame sequencer collecting STAGE duty words and issuing them to the PWM load port
// Optional PWM_SEQ_REPEAT_EN: replay the buffered frame on pwm_done when no new data is offered.
module pwm_load_sequencer #(
    parameter int STAGE  = 8,
    parameter int DWIDTH = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clkfordata,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              pwm_start,
    output logic [DWIDTH-1:0] pwm_data,
    input  logic              pwm_done,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int IDX_W = (STAGE > 1) ? $clog2(STAGE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LOAD    = 2'd2,
        WAIT    = 2'd3
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DWIDTH-1:0] frame_buf [STAGE];
    logic              accept;

    assign accept = in_valid & in_ready;
    assign busy   = (state != IDLE);

    // Outputs are registered alongside the state, so each transition also sets
    // the values the destination state presents in its first cycle.
    always_ff @(posedge clkfordata) begin
        if (rst) begin
            state     <= IDLE;
            wr_idx    <= '0;
            rd_idx    <= '0;
            in_ready  <= 1'b0;
            pwm_start <= 1'b0;
            pwm_data  <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < STAGE; i++) begin
                frame_buf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state    <= COLLECT;
                        in_ready <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (accept) begin
                        frame_buf[wr_idx] <= in_data;
                        if (wr_idx == LAST_IDX) begin
                            // Word 0 was stored earlier in the frame, so it can be issued now.
                            wr_idx    <= '0;
                            in_ready  <= 1'b0;
                            state     <= LOAD;
                            rd_idx    <= '0;
                            pwm_start <= 1'b1;
                            pwm_data  <= frame_buf[0];
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end

                LOAD: begin
                    pwm_start <= 1'b0;
                    if (rd_idx == LAST_IDX) begin
                        state    <= WAIT;
                        rd_idx   <= '0;
                        pwm_data <= '0;
                    end else begin
                        rd_idx   <= rd_idx + 1'b1;
                        pwm_data <= frame_buf[rd_idx + 1'b1];
                    end
                end

                WAIT: begin
                    if (pwm_done) begin
                        frame_cnt <= frame_cnt + 1'b1;
`ifdef PWM_SEQ_REPEAT_EN
                        if (en && !in_valid) begin
                            state     <= LOAD;
                            rd_idx    <= '0;
                            pwm_start <= 1'b1;
                            pwm_data  <= frame_buf[0];
                        end else if (en) begin
                            state    <= COLLECT;
                            in_ready <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
`else
                        if (en) begin
                            state    <= COLLECT;
                            in_ready <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
